// File: rtl/uart_led_ctrl.sv
// uart_led_ctrl: decodes an ASCII command stream into per-channel LED enable
// and PWM brightness, with an RX-activity stretch and command status pulses.
module uart_led_ctrl #(
    parameter int unsigned NUM_LEDS   = 3,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned ACT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [7:0]          rx_byte,
    input  logic                rx_valid,
    output logic [NUM_LEDS-1:0] leds,
    output logic                activity,
    output logic                cmd_ok,
    output logic                cmd_err
);

    localparam int unsigned IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned ACT_W = $clog2(ACT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GET_IDX = 2'd1,
        GET_HI  = 2'd2,
        GET_LO  = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [NUM_LEDS-1:0]  en, en_n;
    logic [7:0]           bright   [NUM_LEDS];
    logic [7:0]           bright_n [NUM_LEDS];
    logic [IDX_W-1:0]     idx, idx_n;
    logic [3:0]           hi, hi_n;
    logic                 ok_n, err_n;
    logic [PWM_BITS-1:0]  pcnt;
    logic [ACT_W-1:0]     act_cnt, act_n;
    logic [NUM_LEDS-1:0]  pwm_on;

    logic [7:0]           dig_off;
    logic                 is_led;
    logic [IDX_W-1:0]     dig_idx;
    logic                 is_hex;
    logic [3:0]           hex_val;

    // Duty comparison; a full-scale duty holds the output high for the whole period.
    function automatic logic duty_hit(input logic [7:0] b, input logic [PWM_BITS-1:0] p);
        logic [PWM_BITS-1:0] d;
        d = b[7 -: PWM_BITS];
        return (d == {PWM_BITS{1'b1}}) || (p < d);
    endfunction

    // Byte classification: in-range channel digit and hex nibble value.
    always_comb begin
        dig_off = rx_byte - 8'h31;
        is_led  = (rx_byte >= 8'h31) && (dig_off < 8'(NUM_LEDS));
        dig_idx = IDX_W'(dig_off);
        is_hex  = 1'b0;
        hex_val = 4'd0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            is_hex  = 1'b1;
            hex_val = rx_byte[3:0];
        end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                     (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
            is_hex  = 1'b1;
            hex_val = rx_byte[3:0] + 4'd9;
        end
    end

    // Parser next-state and channel-register updates; aborting bytes are consumed.
    always_comb begin
        state_n  = state;
        en_n     = en;
        bright_n = bright;
        idx_n    = idx;
        hi_n     = hi;
        ok_n     = 1'b0;
        err_n    = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (is_led) begin
                        en_n[dig_idx] = ~en[dig_idx];
                        ok_n          = 1'b1;
                    end else begin
                        case (rx_byte)
                            8'h41: begin en_n = '1; ok_n = 1'b1; end
                            8'h4F: begin en_n = '0; ok_n = 1'b1; end
                            8'h4C: state_n = GET_IDX;
                            8'h0D, 8'h0A, 8'h20: ;
                            default: err_n = 1'b1;
                        endcase
                    end
                end
                GET_IDX: begin
                    if (is_led) begin
                        idx_n   = dig_idx;
                        state_n = GET_HI;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                GET_HI: begin
                    if (is_hex) begin
                        hi_n    = hex_val;
                        state_n = GET_LO;
                    end else begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
                GET_LO: begin
                    if (is_hex) begin
                        bright_n[idx] = {hi, hex_val};
                        en_n[idx]     = 1'b1;
                        ok_n          = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Activity stretch reloads on every byte, otherwise counts down and parks at zero.
    always_comb begin
        act_n = act_cnt;
        if (rx_valid) begin
            act_n = ACT_W'(ACT_CYCLES);
        end else if (act_cnt != '0) begin
            act_n = act_cnt - ACT_W'(1);
        end
    end

    // Per-channel PWM compare against the free-running counter.
    always_comb begin
        pwm_on = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            pwm_on[i] = duty_hit(bright[i], pcnt);
        end
    end

    // Parser state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Channel settings, PWM counter, activity counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            en       <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                bright[i] <= 8'hFF;
            end
            idx      <= '0;
            hi       <= 4'd0;
            pcnt     <= '0;
            act_cnt  <= '0;
            leds     <= '0;
            activity <= 1'b0;
            cmd_ok   <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            en       <= en_n;
            bright   <= bright_n;
            idx      <= idx_n;
            hi       <= hi_n;
            pcnt     <= pcnt + PWM_BITS'(1);
            act_cnt  <= act_n;
            leds     <= en & pwm_on;
            activity <= (act_n != '0);
            cmd_ok   <= ok_n;
            cmd_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_led_ctrl.sv
// Testbench for uart_led_ctrl: directed literal checks plus randomized byte
// traffic compared every cycle against a command-level reference model.
module tb_uart_led_ctrl;

    localparam int N  = 3;
    localparam int PB = 8;
    localparam int AC = 100;

    logic         clk;
    logic         rstn;
    logic [7:0]   rx_byte;
    logic         rx_valid;
    logic [N-1:0] leds;
    logic         activity;
    logic         cmd_ok;
    logic         cmd_err;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    uart_led_ctrl #(.NUM_LEDS(N), .PWM_BITS(PB), .ACT_CYCLES(AC)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .leds     (leds),
        .activity (activity),
        .cmd_ok   (cmd_ok),
        .cmd_err  (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    // ---------------- reference model ----------------
    bit           m_en [N];
    int           m_br [N];
    int           m_pcnt;
    int           m_act;
    byte unsigned m_q [$];
    logic [N-1:0] exp_leds;
    logic         exp_act, exp_ok, exp_err;

    function automatic int hexv(input byte unsigned b);
        if (b >= "0" && b <= "9") return int'(b) - 'h30;
        if (b >= "A" && b <= "F") return int'(b) - 'h41 + 10;
        if (b >= "a" && b <= "f") return int'(b) - 'h61 + 10;
        return -1;
    endfunction

    function automatic int chan(input byte unsigned b);
        int k;
        k = int'(b) - 'h31;
        if (b >= "1" && b <= "9" && k < N) return k;
        return -1;
    endfunction

    // A pending 'L' command is held as its bytes so far; it completes at four bytes.
    task automatic apply_byte(input byte unsigned b);
        int k;
        if (m_q.size() == 0) begin
            k = chan(b);
            if (k >= 0) begin
                m_en[k] = !m_en[k];
                exp_ok  = 1;
            end else if (b == "A") begin
                foreach (m_en[i]) m_en[i] = 1;
                exp_ok = 1;
            end else if (b == "O") begin
                foreach (m_en[i]) m_en[i] = 0;
                exp_ok = 1;
            end else if (b == "L") begin
                m_q.push_back(b);
            end else if (b != 8'h0D && b != 8'h0A && b != 8'h20) begin
                exp_err = 1;
            end
        end else if (m_q.size() == 1) begin
            if (chan(b) >= 0) m_q.push_back(b);
            else begin exp_err = 1; m_q.delete(); end
        end else begin
            if (hexv(b) < 0) begin
                exp_err = 1;
                m_q.delete();
            end else begin
                m_q.push_back(b);
                if (m_q.size() == 4) begin
                    k       = chan(m_q[1]);
                    m_br[k] = hexv(m_q[2]) * 16 + hexv(m_q[3]);
                    m_en[k] = 1;
                    exp_ok  = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    always @(posedge clk) begin
        int d;
        if (!rstn) begin
            foreach (m_en[i]) begin m_en[i] = 0; m_br[i] = 255; end
            m_pcnt   = 0;
            m_act    = 0;
            m_q.delete();
            exp_leds = '0;
            exp_act  = 0;
            exp_ok   = 0;
            exp_err  = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                d = m_br[i] >> (8 - PB);
                exp_leds[i] = m_en[i] && (d == (1 << PB) - 1 || m_pcnt < d);
            end
            m_pcnt = (m_pcnt + 1) % (1 << PB);
            if (rx_valid) m_act = AC;
            else if (m_act > 0) m_act--;
            exp_act = (m_act != 0);
            exp_ok  = 0;
            exp_err = 0;
            if (rx_valid) apply_byte(rx_byte);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("leds",     int'(leds),     int'(exp_leds));
            check("activity", int'(activity), int'(exp_act));
            check("cmd_ok",   int'(cmd_ok),   int'(exp_ok));
            check("cmd_err",  int'(cmd_err),  int'(exp_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input byte unsigned b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic count_led0(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (leds[0]) cnt++;
        end
    endtask

    byte unsigned pool [24] = '{"1", "2", "3", "4", "L", "L", "L", "L", "A", "O",
                                "0", "9", "F", "f", "a", "c", "8", "G", "z", 8'h0D,
                                8'h0A, 8'h20, "5", "B"};

    initial begin
        int cnt;
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset_leds", int'(leds), 0);
        check("reset_activity", int'(activity), 0);
        rstn = 1'b1;

        // Toggle channel 2 on then off.
        send("2");
        check("toggle_ok", int'(cmd_ok), 1);
        @(negedge clk);
        check("toggle_on_leds", int'(leds), 3'b010);
        send("2");
        @(negedge clk);
        check("toggle_off_leds", int'(leds), 3'b000);

        // Errors: out-of-range channel and bad hex digit.
        send("5");
        check("bad_chan_err", int'(cmd_err), 1);
        send("L"); send("1"); send("G");
        check("bad_hex_err", int'(cmd_err), 1);
        send("A");
        @(negedge clk);
        check("all_on_leds", int'(leds), 3'b111);
        send("O");
        @(negedge clk);
        check("all_off_leds", int'(leds), 3'b000);

        // Quarter duty on channel 1, then zero duty.
        send("L"); send("1"); send("4"); send("0");
        check("bright_ok", int'(cmd_ok), 1);
        @(negedge clk);
        count_led0(256, cnt);
        check("duty_40_count", cnt, 64);
        send("L"); send("1"); send("0"); send("0");
        @(negedge clk);
        count_led0(256, cnt);
        check("duty_00_count", cnt, 0);

        // Reset in the middle of a brightness command.
        send("L"); send("3"); send("8");
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midreset_leds", int'(leds), 0);
        check("midreset_activity", int'(activity), 0);
        send("F");
        check("after_reset_err", int'(cmd_err), 1);
        check("after_reset_no_ok", int'(cmd_ok), 0);

        // Activity stretch: single byte, then reload at cycle 50.
        repeat (AC + 5) @(negedge clk);
        send(8'h0D);
        check("cr_no_ok", int'(cmd_ok), 0);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (activity) cnt++;
        end
        check("act_single_len", cnt, 100);
        @(negedge clk);
        rx_byte = 8'h0D; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 300; n++) begin
            if (activity) cnt++;
            if (n == 50) begin rx_valid = 1'b1; rx_byte = 8'h0D; end
            else rx_valid = 1'b0;
            @(negedge clk);
        end
        check("act_reload_len", cnt, 150);

        // Back-to-back bytes.
        @(negedge clk);
        rx_byte = "A"; rx_valid = 1'b1;
        @(negedge clk);
        rx_byte = "O";
        check("b2b_ok_a", int'(cmd_ok), 1);
        @(negedge clk);
        rx_valid = 1'b0;
        check("b2b_ok_o", int'(cmd_ok), 1);
        repeat (2) @(negedge clk);
        check("b2b_leds", int'(leds), 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            rstn     = ($urandom_range(0, 499) != 0);
            rx_valid = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 15) == 0) rx_byte = 8'($urandom);
            else rx_byte = pool[$urandom_range(0, 23)];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rstn     = 1'b1;
        repeat (5) @(negedge clk);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
